// File: rtl/debug_dump_controller.sv
// Debug register-file dump controller.
// Freezes the core, then walks the register file one entry at a time.
// Each 32-bit register is sent to a byte transmitter, least significant byte first.
// The dump can be aborted at any point and ends with a one-cycle done pulse.
module debug_dump_controller #(
    parameter int NUM_REGS     = 32,
    parameter int STALL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] reg_data,
    input  logic        tx_ready,
    output logic        stop_debug,
    output logic        debug_on,
    output logic [4:0]  debug_read_reg,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        STALL,
        SETREG,
        CAPTURE,
        SEND,
        NEXT,
        DONE
    } state_t;

    localparam logic [4:0] LAST_IDX   = 5'(NUM_REGS - 1);
    localparam logic [7:0] STALL_LOAD = 8'(STALL_CYCLES - 1);

    state_t      state, stateNext;
    logic [4:0]  index, indexNext;
    logic [7:0]  stallCnt, stallCntNext;
    logic [1:0]  byteCnt, byteCntNext;
    logic [31:0] shiftReg, shiftRegNext;

    // State and datapath registers; reset clears everything back to an idle, empty dump.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            index    <= '0;
            stallCnt <= '0;
            byteCnt  <= '0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            index    <= indexNext;
            stallCnt <= stallCntNext;
            byteCnt  <= byteCntNext;
            shiftReg <= shiftRegNext;
        end
    end

    // Next-state logic: walk STALL -> (SETREG, CAPTURE, SEND x4, NEXT) per register -> DONE.
    always_comb begin
        stateNext    = state;
        indexNext    = index;
        stallCntNext = stallCnt;
        byteCntNext  = byteCnt;
        shiftRegNext = shiftReg;
        case (state)
            IDLE: begin
                // Abort beats a simultaneous start so the core is never frozen by accident.
                if (start && !abort) begin
                    stateNext    = STALL;
                    stallCntNext = STALL_LOAD;
                end
            end
            STALL: begin
                if (stallCnt == '0) begin
                    stateNext = SETREG;
                    indexNext = '0;
                end else begin
                    stallCntNext = stallCnt - 8'd1;
                end
            end
            SETREG: begin
                // Register file needs one cycle after the index changes before data is valid.
                stateNext = CAPTURE;
            end
            CAPTURE: begin
                shiftRegNext = reg_data;
                byteCntNext  = '0;
                stateNext    = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    shiftRegNext = shiftReg >> 8;
                    byteCntNext  = byteCnt + 2'd1;
                    if (byteCnt == 2'd3) begin
                        stateNext = NEXT;
                    end
                end
            end
            NEXT: begin
                if (index == LAST_IDX) begin
                    stateNext = DONE;
                end else begin
                    indexNext = index + 5'd1;
                    stateNext = SETREG;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (abort && (state != IDLE)) begin
            stateNext = IDLE;
        end
    end

    // Output decode: every output is a function of state plus registered data only.
    always_comb begin
        stop_debug     = 1'b0;
        debug_on       = 1'b0;
        debug_read_reg = '0;
        tx_valid       = 1'b0;
        tx_data        = '0;
        busy           = (state != IDLE);
        done           = (state == DONE);
        case (state)
            STALL, NEXT: begin
                stop_debug = 1'b1;
                debug_on   = 1'b1;
            end
            SETREG, CAPTURE: begin
                stop_debug     = 1'b1;
                debug_on       = 1'b1;
                debug_read_reg = index;
            end
            SEND: begin
                stop_debug     = 1'b1;
                debug_on       = 1'b1;
                debug_read_reg = index;
                tx_valid       = 1'b1;
                tx_data        = shiftReg[7:0];
            end
            default: begin
                stop_debug = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_dump_controller.sv
// Scoreboard testbench for debug_dump_controller.
module tb_debug_dump_controller;

    localparam int NUM_REGS     = 32;
    localparam int STALL_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] regData;
    logic        txReady;
    logic        stop_debug;
    logic        debug_on;
    logic [4:0]  debug_read_reg;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;

    int          mode = 0;
    logic [7:0]  expQ[$];
    int          checkCnt = 0;
    int          passCnt = 0;
    int          xferCnt = 0;
    int          doneCnt = 0;
    int          stopCnt = 0;
    logic        prevValid = 1'b0;
    logic        prevReady = 1'b0;
    logic        prevAbort = 1'b0;
    logic        prevRst = 1'b0;
    logic [7:0]  prevData = '0;

    debug_dump_controller #(
        .NUM_REGS    (NUM_REGS),
        .STALL_CYCLES(STALL_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .reg_data      (regData),
        .tx_ready      (txReady),
        .stop_debug    (stop_debug),
        .debug_on      (debug_on),
        .debug_read_reg(debug_read_reg),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] modelWord(input logic [4:0] idx, input int m);
        case (m)
            0:       return 32'h11223300 + 32'(idx);
            1:       return 32'hDEADBEEF;
            default: return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
        endcase
    endfunction

    // Register file model: read data appears one cycle after the index is presented.
    always @(posedge clk) regData <= modelWord(debug_read_reg, mode);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushReg(input int idx, input int nBytes);
        logic [31:0] w;
        w = modelWord(5'(idx), mode);
        for (int b = 0; b < nBytes; b++) expQ.push_back(w[8*b +: 8]);
    endtask

    task automatic startDump();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input bit bp, input bit pokeStart);
        bit seen;
        bit poked;
        seen  = 1'b0;
        poked = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bp) txReady = ((i % 4) == 0) || ((i % 4) == 3);
            step();
            start = 1'b0;
            if (pokeStart && !poked && tx_valid) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_stop_debug"}, 32'(stop_debug), 32'd0);
        check({tag, "_debug_on"}, 32'(debug_on), 32'd0);
        check({tag, "_read_reg"}, 32'(debug_read_reg), 32'd0);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic clearCounts();
        xferCnt = 0;
        doneCnt = 0;
        stopCnt = 0;
    endtask

    // Monitor: pops the scoreboard on every transfer and checks bytes are held under backpressure.
    always @(negedge clk) begin
        if (prevValid && !prevReady && !prevAbort && !prevRst)
            check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prevData});
        if (tx_valid && txReady) begin
            xferCnt++;
            if (expQ.size() == 0) check("byte_unexpected", 32'(expQ.size()), 32'd1);
            else check("tx_byte", 32'(tx_data), 32'(expQ.pop_front()));
        end
        if (done) doneCnt++;
        if (stop_debug) stopCnt++;
        prevValid = tx_valid;
        prevReady = txReady;
        prevAbort = abort;
        prevRst   = rst;
        prevData  = tx_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [31:0] w;
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        txReady = 1'b0;
        repeat (3) step();
        checkAllZero("reset");
        rst = 1'b0;
        step();

        // Full dump, transmitter always ready.
        mode    = 0;
        txReady = 1'b1;
        clearCounts();
        for (int r = 0; r < NUM_REGS; r++) pushReg(r, 4);
        startDump();
        waitDone(600, 1'b0, 1'b0);
        check("full_stop_cycles", 32'(stopCnt), 32'(STALL_CYCLES + NUM_REGS * 7));
        check("full_xfers", 32'(xferCnt), 32'(4 * NUM_REGS));
        check("full_queue", 32'(expQ.size()), 32'd0);
        step();
        check("full_done_count", 32'(doneCnt), 32'd1);
        check("full_done_low", 32'(done), 32'd0);
        check("full_busy_low", 32'(busy), 32'd0);

        // Backpressure 1,0,0,1 with a start pulse injected during SEND.
        mode = 1;
        clearCounts();
        for (int r = 0; r < NUM_REGS; r++) pushReg(r, 4);
        txReady = 1'b1;
        startDump();
        waitDone(2000, 1'b1, 1'b1);
        txReady = 1'b1;
        step();
        check("bp_done_count", 32'(doneCnt), 32'd1);
        check("bp_xfers", 32'(xferCnt), 32'(4 * NUM_REGS));
        check("bp_queue", 32'(expQ.size()), 32'd0);
        repeat (10) step();
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("bp_idle_xfers", 32'(xferCnt), 32'(4 * NUM_REGS));

        // Abort during SEND of register 5, byte 2, after a long stall on tx_ready.
        mode = 2;
        clearCounts();
        expQ.delete();
        for (int r = 0; r < 5; r++) pushReg(r, 4);
        pushReg(5, 2);
        txReady = 1'b1;
        startDump();
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (tx_valid && xferCnt == 22) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reached", 32'(found), 32'd1);
        check("abort_reg_index", 32'(debug_read_reg), 32'd5);
        txReady = 1'b0;
        repeat (10) step();
        w = modelWord(5'd5, 2);
        check("stall_tx_valid", 32'(tx_valid), 32'd1);
        check("stall_tx_data", 32'(tx_data), 32'(w[23:16]));
        check("stall_xfers", 32'(xferCnt), 32'd22);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_stop_debug", 32'(stop_debug), 32'd0);
        check("abort_debug_on", 32'(debug_on), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        step();
        check("abort_done_count", 32'(doneCnt), 32'd0);
        check("abort_queue", 32'(expQ.size()), 32'd0);

        // Restart after abort begins at index 0.
        clearCounts();
        for (int r = 0; r < NUM_REGS; r++) pushReg(r, 4);
        txReady = 1'b1;
        startDump();
        waitDone(600, 1'b0, 1'b0);
        step();
        check("restart_xfers", 32'(xferCnt), 32'(4 * NUM_REGS));
        check("restart_queue", 32'(expQ.size()), 32'd0);
        check("restart_done_count", 32'(doneCnt), 32'd1);

        // Reset asserted in SETREG of register 10.
        mode = 0;
        clearCounts();
        for (int r = 0; r < 10; r++) pushReg(r, 4);
        startDump();
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (debug_read_reg == 5'd10) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_reached", 32'(found), 32'd1);
        rst = 1'b1;
        step();
        checkAllZero("midrst");
        rst = 1'b0;
        step();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_xfers", 32'(xferCnt), 32'd40);
        check("midrst_queue", 32'(expQ.size()), 32'd0);
        check("midrst_done_count", 32'(doneCnt), 32'd0);

        // Simultaneous start and abort in IDLE.
        start = 1'b1;
        abort = 1'b1;
        step();
        check("both_busy", 32'(busy), 32'd0);
        check("both_stop_debug", 32'(stop_debug), 32'd0);
        start = 1'b0;
        abort = 1'b0;
        step();
        check("both_busy_after", 32'(busy), 32'd0);
        check("both_stop_after", 32'(stop_debug), 32'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
